// File: rtl/seg_scan_mux_pkg.sv
// Shared definitions for the seven-segment scan multiplexer: the dark segment
// value, scan FSM state encodings and the digit-select polarity helper.
package seg_scan_mux_pkg;

    // Panel-native "all segments off" for active-low segment drivers.
    localparam logic [7:0] SEG_OFF_DEFAULT = 8'hFF;

    // Widest digit count the select helper can decode.
    localparam int MAX_SEG = 32;
    localparam int SEL_W   = $clog2(MAX_SEG);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // One-hot digit select, inverted when the panel anodes are active-low.
    function automatic logic [MAX_SEG-1:0] an_select(input logic [SEL_W-1:0] idx,
                                                     input logic active_low);
        logic [MAX_SEG-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return active_low ? ~onehot : onehot;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Digit slot timer: counts clk cycles within one digit slot (blank + show)
// and flags the last blank cycle and the last cycle of the slot.
module seg_slot_timer #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    run,
    output logic [$clog2(DIV)-1:0]  slot_cnt,
    output logic                    blank_end,
    output logic                    slot_end
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIV - 1);

    // Strobes decode the current count; the FSM qualifies them with its state.
    assign blank_end = (slot_cnt == BLANK_LAST);
    assign slot_end  = (slot_cnt == SLOT_LAST);

    // Slot counter: wraps at DIV-1 so it never runs past the slot length.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            slot_cnt <= '0;
        end else if (clear) begin
            slot_cnt <= '0;
        end else if (run) begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver. Snapshots the parallel
// segment bus once per frame and scans it one digit at a time, with a blank
// dead time ahead of every digit to suppress ghosting.
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int         NUM_SEG       = 6,
    parameter int         DIV           = 50000,
    parameter int         BLANK         = 500,
    parameter logic [7:0] SEG_OFF       = SEG_OFF_DEFAULT,
    parameter bit         AN_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_SEG*8-1:0]   seg_in,
    output logic [7:0]             seg_out,
    output logic [NUM_SEG-1:0]     an_out,
    output logic                   frame_done
);

    localparam int DIG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [DIG_W-1:0]   DIG_LAST = DIG_W'(NUM_SEG - 1);
    localparam logic [NUM_SEG-1:0] AN_DARK  = AN_ACTIVE_LOW ? '1 : '0;

    scan_state_t                  state;
    logic [DIG_W-1:0]             dig;
    logic [NUM_SEG-1:0][7:0]      snapshot;
    logic [CNT_W-1:0]             slot_cnt;
    logic                         blank_end;
    logic                         slot_end;
    logic                         tmr_clear;
    logic                         tmr_run;
    logic [MAX_SEG-1:0]           an_sel_full;

    // The timer idles at zero outside a scan and whenever scanning is disabled.
    assign tmr_clear = !enable || (state == ST_IDLE);
    assign tmr_run   = (state != ST_IDLE);

    seg_slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (tmr_clear),
        .run       (tmr_run),
        .slot_cnt  (slot_cnt),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    // Decode the current digit into a panel-polarity select word.
    always_comb begin
        an_sel_full = an_select(SEL_W'(dig), AN_ACTIVE_LOW);
    end

    // Scan FSM with registered outputs; outputs reflect the previous state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            dig        <= '0;
            // NOTE: the snapshot is only NUM_SEG bytes of flops, so it is reset
            // to dark like everything else rather than left uninitialised.
            snapshot   <= {NUM_SEG{SEG_OFF}};
            seg_out    <= SEG_OFF;
            an_out     <= AN_DARK;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= (state == ST_SHOW) ? snapshot[dig] : SEG_OFF;
            an_out     <= (state == ST_SHOW) ? an_sel_full[NUM_SEG-1:0] : AN_DARK;
            frame_done <= 1'b0;

            if (!enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        snapshot <= seg_in;
                        dig      <= '0;
                        state    <= ST_BLANK;
                    end
                    ST_BLANK: begin
                        if (blank_end) begin
                            state <= ST_SHOW;
                        end
                    end
                    ST_SHOW: begin
                        if (slot_end) begin
                            state <= ST_BLANK;
                            if (dig == DIG_LAST) begin
                                dig        <= '0;
                                frame_done <= 1'b1;
                                snapshot   <= seg_in;
                            end else begin
                                dig <= dig + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (NUM_SEG=6, DIV=8, BLANK=2, 10 ns clk).
// Directed table-driven scan plus corner sequences, with a frame-position
// reference model compared every cycle.
module tb_seg_scan_mux;

    localparam int NUM_SEG = 6;
    localparam int DIV     = 8;
    localparam int BLANK   = 2;
    localparam int FRAME   = NUM_SEG * DIV;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic [NUM_SEG*8-1:0]   seg_in;
    logic [7:0]             seg_out;
    logic [NUM_SEG-1:0]     an_out;
    logic                   frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    seg_scan_mux #(
        .NUM_SEG       (NUM_SEG),
        .DIV           (DIV),
        .BLANK         (BLANK),
        .SEG_OFF       (8'hFF),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the scan as a position within the frame: digit = pos/DIV,
    // lit once the in-slot offset reaches BLANK. Expected outputs after an
    // edge describe the scan position held before that edge.
    bit          m_active = 1'b0;
    int          m_pos    = 0;
    logic [7:0]  m_img [NUM_SEG];
    logic [7:0]          exp_seg = 8'hFF;
    logic [NUM_SEG-1:0]  exp_an  = '1;
    logic                exp_fd  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            exp_seg  = 8'hFF;
            exp_an   = '1;
            exp_fd   = 1'b0;
        end else begin
            int q;
            int d;
            q = m_pos % FRAME;
            d = q / DIV;
            if (m_active && (q % DIV) >= BLANK) begin
                exp_seg = m_img[d];
                exp_an  = ~(NUM_SEG'(1) << d);
            end else begin
                exp_seg = 8'hFF;
                exp_an  = '1;
            end
            exp_fd = m_active && (q == FRAME - 1);
            if (!enable) begin
                m_active = 1'b0;
            end else if (!m_active || q == FRAME - 1) begin
                for (int k = 0; k < NUM_SEG; k++) m_img[k] = seg_in[8*k +: 8];
                m_pos    = 0;
                m_active = 1'b1;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    end

    // Per-cycle comparison against the model, plus anode exclusivity.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_seg", 32'(seg_out), 32'(exp_seg));
            check("mon_an", 32'(an_out), 32'(exp_an));
            check("mon_fd", 32'(frame_done), 32'(exp_fd));
            check("an_exclusive", 32'($countones(~an_out) <= 1), 32'd1);
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_dark(input string tag);
        check({tag, "_seg"}, 32'(seg_out), 32'h0FF);
        check({tag, "_an"}, 32'(an_out), 32'h03F);
        check({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    // Step until frame_done is seen; n is the number of samples taken.
    task automatic wait_fd(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        check("fd_seen", 32'(frame_done), 32'd1);
    endtask

    // Step until the first lit sample; n counts dark samples before it.
    task automatic count_dark(output int n);
        n = 0;
        step();
        while (an_out === 6'h3F && n < 20) begin
            n++;
            step();
        end
    endtask

    typedef struct {
        logic [7:0]         seg;
        logic [NUM_SEG-1:0] an;
    } vec_t;

    vec_t vecs [NUM_SEG];

    initial begin
        int n;

        vecs[0] = '{seg: 8'hC0, an: 6'b111110};
        vecs[1] = '{seg: 8'hF9, an: 6'b111101};
        vecs[2] = '{seg: 8'hA4, an: 6'b111011};
        vecs[3] = '{seg: 8'hB0, an: 6'b110111};
        vecs[4] = '{seg: 8'h99, an: 6'b101111};
        vecs[5] = '{seg: 8'h92, an: 6'b011111};

        // 1. Reset held with enable high and random input.
        rst    = 1'b1;
        enable = 1'b1;
        seg_in = 48'({$urandom(), $urandom()});
        repeat (4) begin
            step();
            expect_dark("rst_hold");
            seg_in = 48'({$urandom(), $urandom()});
        end

        // 2. Basic scan from the digit table.
        for (int k = 0; k < NUM_SEG; k++) seg_in[8*k +: 8] = vecs[k].seg;
        mon_en = 1'b1;
        rst    = 1'b0;
        step();
        expect_dark("post_rst");
        for (int d = 0; d < NUM_SEG; d++) begin
            repeat (BLANK) begin
                step();
                expect_dark("scan_blank");
            end
            for (int r = 0; r < DIV - BLANK; r++) begin
                step();
                check("scan_seg", 32'(seg_out), 32'(vecs[d].seg));
                check("scan_an", 32'(an_out), 32'(vecs[d].an));
                check("scan_fd", 32'(frame_done),
                      32'((d == NUM_SEG - 1) && (r == DIV - BLANK - 1)));
            end
        end
        wait_fd(n);
        check("frame_period", 32'(n), 32'(FRAME));

        // 3. Tear-free update: change digit 1 while digit 3 shows.
        repeat (3 * DIV + BLANK + 1) step();
        check("tear_d3_an", 32'(an_out), 32'(vecs[3].an));
        seg_in[15:8] = 8'h80;
        wait_fd(n);
        check("tear_fd_gap", 32'(n), 32'(FRAME - (3 * DIV + BLANK + 1)));
        repeat (DIV + BLANK + 1) step();
        check("tear_new_seg", 32'(seg_out), 32'h080);
        check("tear_new_an", 32'(an_out), 32'(vecs[1].an));

        // 4. Enable drop during digit 2.
        wait_fd(n);
        repeat (2 * DIV + BLANK + 1) step();
        check("endrop_lit_an", 32'(an_out), 32'(vecs[2].an));
        enable = 1'b0;
        step();
        check("endrop_lag_an", 32'(an_out), 32'(vecs[2].an));
        step();
        expect_dark("endrop_dark");
        repeat (10) begin
            step();
            expect_dark("endrop_idle");
        end
        enable = 1'b1;
        count_dark(n);
        check("reen_dark_cnt", 32'(n), 32'(BLANK + 1));
        check("reen_an", 32'(an_out), 32'(vecs[0].an));
        check("reen_seg", 32'(seg_out), 32'(vecs[0].seg));

        // 5. Asynchronous reset pulse between edges during digit 4.
        wait_fd(n);
        repeat (4 * DIV + BLANK + 1) step();
        check("arst_lit_an", 32'(an_out), 32'(vecs[4].an));
        #1 rst = 1'b1;
        #1 expect_dark("arst_now");
        #2 rst = 1'b0;
        count_dark(n);
        check("arst_dark_cnt", 32'(n), 32'(BLANK + 1));
        check("arst_an", 32'(an_out), 32'(vecs[0].an));

        // 6. Randomised scanning: continuous frames, then random enable drops.
        repeat (10 * FRAME) begin
            step();
            seg_in = 48'({$urandom(), $urandom()});
        end
        repeat (300) begin
            step();
            seg_in = 48'({$urandom(), $urandom()});
            enable = ($urandom_range(0, 99) != 0);
        end
        enable = 1'b1;
        repeat (2) step();

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream stage of led_test. Consumes its parallel seven-segment bus (NUM_SEG digits x 8 bits) and drives a time-multiplexed common-anode panel: one shared 8-bit segment bus plus one digit-select line per digit.
- Inserts a blanking dead time between digits to suppress ghosting.
- Snapshots the input bus once per frame so a display update mid-scan never tears.

Parameters:
- NUM_SEG, 6: number of digits; must match led_test NUM_SEG.
- DIV, 50000: clk cycles per digit slot (blank plus show); DIV >= 2.
- BLANK, 500: dead cycles at the start of each slot; 1 <= BLANK < DIV.
- SEG_OFF, 8'hFF: segment value driven while blanked (panel-native, active-low segments).
- AN_ACTIVE_LOW, 1: 1 means digit-select asserted low; 0 means asserted high.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  scan enable; low forces the panel dark
- seg_in  in  NUM_SEG*8  parallel segment bus from led_test; digit k at [8k+7:8k], already panel polarity
- seg_out  out  8  shared segment bus to panel
- an_out  out  NUM_SEG  digit selects; bit k selects digit k
- frame_done  out  1  one-cycle pulse at the end of each complete scan frame

Behaviour:
- Clocking and reset:
  - Single clock domain, one clock: clk. Reset rst is asynchronous and active-high; every flop clears on assertion, with no clock needed.
  - Reset values: seg_out = SEG_OFF; an_out = all deasserted (all 1s when AN_ACTIVE_LOW=1); frame_done = 0; state = IDLE; slot_cnt = 0; dig = 0; snapshot = {NUM_SEG{SEG_OFF}}.
- State machine: IDLE, BLANK, SHOW.
- IDLE:
  - Outputs are dark.
  - On a cycle with enable=1: capture snapshot <= seg_in, set dig=0 and slot_cnt=0, go to BLANK.
- BLANK:
  - Outputs are dark.
  - slot_cnt increments each cycle. When slot_cnt == BLANK-1, go to SHOW.
- SHOW:
  - seg_out = snapshot[dig]; an_out asserts bit dig only.
  - slot_cnt increments each cycle. When slot_cnt == DIV-1: reset slot_cnt to 0 and go to BLANK.
  - At that slot end, dig increments. If dig == NUM_SEG-1, dig wraps to 0 instead, frame_done is set, and snapshot <= seg_in is recaptured on the same cycle.
- Counter widths: slot_cnt is $clog2(DIV) bits; dig is $clog2(NUM_SEG) bits (minimum 1). No overflow past DIV-1 or NUM_SEG-1.
- Outputs are registered; seg_out, an_out and frame_done change only on a clk edge and lag the state register by 1 cycle.
- Per-digit timing: the anode is asserted for exactly DIV-BLANK consecutive cycles, preceded by BLANK dark cycles.
- Frame length is NUM_SEG*DIV cycles, with no idle cycle between frames.
- frame_done: high for exactly 1 cycle, in the cycle after the last SHOW cycle of digit NUM_SEG-1.
- Anode exclusivity: never more than one an_out bit asserted. An anode and a non-SEG_OFF segment value never change on the same edge in a way that lights the wrong digit, because a blank slot always separates digits.
- enable deasserted in any state: next edge goes to IDLE, outputs go dark 1 cycle later, no frame_done. Re-enable restarts at digit 0 with a fresh snapshot.
- seg_in changes mid-frame: ignored until the next frame capture.
- rst mid-frame: immediate dark outputs; scan restarts from IDLE after release.

Decomposition:
- Add to myPkg.v:
  - SEG_OFF default constant.
  - State encodings for IDLE, BLANK and SHOW.
  - An anode-polarity helper function returning a one-hot or inverted one-hot select from dig.
- One natural sub-module, seg_slot_timer: the slot_cnt counter with blank_end and slot_end strobes, parameterised by DIV and BLANK.
- Digit/snapshot control and output registers stay in seg_scan_mux.

Test Plan:
All scenarios use NUM_SEG=6, DIV=8, BLANK=2 and a 10 ns clk.
1. Reset: hold rst=1 with enable=1 and seg_in random -> seg_out=8'hFF, an_out=6'b111111, frame_done=0 throughout; stays dark 1 cycle after release.
2. Basic scan: seg_in = digits 0..5 as 8'hC0, F9, A4, B0, 99, 92 -> each digit shows exactly 6 cycles after 2 dark cycles. Expected an_out sequence 111110, 111101, ..., 011111 with matching seg_out. frame_done pulses every 48 cycles.
3. Tear-free update: change seg_in[15:8] from F9 to 80 while digit 3 is showing -> digit 1 shows F9 until the next frame, then 80.
4. Enable drop: deassert enable during SHOW of digit 2 -> dark output 2 edges later, no frame_done. Re-enable -> first lit digit is 0 after 2 blank cycles.
5. Async reset mid-frame: pulse rst for 3 ns between edges during digit 4 -> outputs dark immediately without waiting for a clk edge; restart at digit 0.
6. Exclusivity check: run 10 frames with random seg_in -> the assertion "popcount of asserted an_out <= 1" never fails.
